// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared FSM state type and default sizing for the bus arbiter.
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANTED, BUSY, RELEASE} arb_state_t;
  localparam int DEF_NUM_MASTERS = 2;
  localparam int DEF_GRANT_TIMEOUT = 16;
endpackage

// File: rtl/bus_arbiter_picker.sv
// arb_picker: combinational winner selection; BUS_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
module arb_picker import bus_arb_pkg::*; #(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  localparam int IDW = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDW-1:0]         last_winner_i,
  output logic                   valid_o,
  output logic [IDW-1:0]         winner_o
);
`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [IDW:0] idx;
  always_comb begin
    valid_o = |req_i;
    winner_o = '0;
    idx = '0;
    // walk downward from the farthest candidate so the nearest set bit after last_winner wins
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = (IDW+1)'(last_winner_i) + (IDW+1)'(k + 1);
      if (idx >= (IDW+1)'(NUM_MASTERS)) idx = idx - (IDW+1)'(NUM_MASTERS);
      if (req_i[idx[IDW-1:0]]) winner_o = idx[IDW-1:0];
    end
  end
`else
  logic unused_lw;
  assign unused_lw = ^last_winner_i;
  always_comb begin
    valid_o = |req_i;
    winner_o = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (req_i[k]) winner_o = IDW'(k);
  end
`endif
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: grants the shared bus to one master at a time with a turnaround cycle and unused-grant timeout.
// Arbitration scheme chosen in arb_picker by BUS_ARB_ROUND_ROBIN_EN (round-robin) or fixed priority when undefined.
module bus_arbiter import bus_arb_pkg::*; #(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  localparam int IDW = $clog2(NUM_MASTERS),
  localparam int CW = $clog2(GRANT_TIMEOUT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] util,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDW-1:0]         grant_id,
  output logic                   bus_busy,
  output logic                   timeout,
  output logic                   util_err
);
  arb_state_t             state_q;
  logic [CW-1:0]          cnt_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDW-1:0]         id_q;
  logic [IDW-1:0]         last_q;
  logic                   timeout_q;
  logic                   util_err_q;
  logic                   pick_valid;
  logic [IDW-1:0]         pick_id;

  arb_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req_i         (req),
    .last_winner_i (last_q),
    .valid_o       (pick_valid),
    .winner_o      (pick_id)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      grant_q <= '0;
      id_q <= '0;
      last_q <= IDW'(NUM_MASTERS - 1);
      timeout_q <= 1'b0;
      util_err_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      util_err_q <= |(util & ~grant_q);
      case (state_q)
        IDLE:
          if (pick_valid) begin
            grant_q <= NUM_MASTERS'(1) << pick_id;
            id_q <= pick_id;
            state_q <= GRANTED;
          end
        GRANTED:
          if (util[id_q]) state_q <= BUSY;
          else if (!req[id_q] || cnt_q == CW'(GRANT_TIMEOUT - 1)) begin
            timeout_q <= req[id_q];
            grant_q <= '0;
            state_q <= RELEASE;
          end else cnt_q <= cnt_q + 1'b1;
        BUSY:
          if (!util[id_q]) begin
            grant_q <= '0;
            state_q <= RELEASE;
          end
        RELEASE: begin
          last_q <= id_q;
          cnt_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign grant_id = id_q;
  assign bus_busy = state_q != IDLE;
  assign timeout = timeout_q;
  assign util_err = util_err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of grant sequencing, turnaround, timeout, util_err and async reset.
module tb_bus_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] util = 2'b00;
  logic [1:0] grant;
  logic       grant_id;
  logic       bus_busy;
  logic       timeout;
  logic       util_err;
  int total = 0;
  int bad = 0;

  bus_arbiter #(.NUM_MASTERS(2), .GRANT_TIMEOUT(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .util     (util),
    .grant    (grant),
    .grant_id (grant_id),
    .bus_busy (bus_busy),
    .timeout  (timeout),
    .util_err (util_err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = 2'b00;
    util = 2'b00;
    step(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 2'b01;
    util = 2'b00;
    step(2);
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
    total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL reset_id got=%b exp=0", grant_id); end
    total++; if (bus_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus_busy); end
    total++; if (timeout !== 1'b0 || util_err !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", timeout, util_err); end
    req = 2'b00;
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_single();
    do_reset();
    req = 2'b01;
    step(1);
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", grant); end
    total++; if (bus_busy !== 1'b1) begin bad++; $display("FAIL single_busy_granted got=%b exp=1", bus_busy); end
    step(1);
    util = 2'b01;
    req = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step(1);
      total++; if (grant !== 2'b01 || bus_busy !== 1'b1) begin bad++; $display("FAIL single_hold%0d got=%b/%b exp=01/1", i, grant, bus_busy); end
    end
    util = 2'b00;
    step(1);
    total++; if (grant !== 2'b00 || bus_busy !== 1'b1) begin bad++; $display("FAIL single_release got=%b/%b exp=00/1", grant, bus_busy); end
    step(1);
    total++; if (grant !== 2'b00 || bus_busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b/%b exp=00/0", grant, bus_busy); end
    total++; if (util_err !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL single_pulses got=%b%b exp=00", timeout, util_err); end
  endtask

  task automatic test_priority();
    do_reset();
    req = 2'b11;
    step(1);
    total++; if (grant !== 2'b01 || grant_id !== 1'b0) begin bad++; $display("FAIL prio_first got=%b/%b exp=01/0", grant, grant_id); end
    util = 2'b01;
    req = 2'b10;
    step(1);
    util = 2'b00;
    step(1);
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL prio_fall got=%b exp=00", grant); end
    step(1);
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL prio_gap got=%b exp=00", grant); end
    step(1);
    total++; if (grant !== 2'b10 || grant_id !== 1'b1) begin bad++; $display("FAIL prio_second got=%b/%b exp=10/1", grant, grant_id); end
    req = 2'b00;
    step(1);
    total++; if (grant !== 2'b00 || timeout !== 1'b0) begin bad++; $display("FAIL prio_withdraw got=%b/%b exp=00/0", grant, timeout); end
    step(1);
  endtask

  task automatic test_order();
`ifdef BUS_ARB_ROUND_ROBIN_EN
    int exp_ord[4] = '{0, 1, 0, 1};
`else
    int exp_ord[4] = '{0, 0, 0, 0};
`endif
    do_reset();
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      step(1);
      total++; if (grant !== 2'(1 << exp_ord[t]) || grant_id !== 1'(exp_ord[t])) begin bad++; $display("FAIL order%0d got=%b/%b exp_id=%0d", t, grant, grant_id, exp_ord[t]); end
      util = 2'(1 << exp_ord[t]);
      step(1);
      util = 2'b00;
      step(2);
    end
    req = 2'b00;
    step(2);
  endtask

  task automatic test_timeout();
    do_reset();
    req = 2'b10;
    step(1);
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL to_grant got=%b exp=10", grant); end
    for (int k = 1; k < 16; k++) begin
      step(1);
      total++; if (grant !== 2'b10 || timeout !== 1'b0) begin bad++; $display("FAIL to_wait%0d got=%b/%b exp=10/0", k, grant, timeout); end
    end
    step(1);
    total++; if (timeout !== 1'b1 || grant !== 2'b00) begin bad++; $display("FAIL to_pulse got=%b/%b exp=1/00", timeout, grant); end
    step(1);
    total++; if (timeout !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL to_after got=%b/%b exp=0/00", timeout, grant); end
    step(1);
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL to_regrant got=%b exp=10", grant); end
    req = 2'b00;
    step(1);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_withdraw got=%b exp=0", timeout); end
    step(1);
  endtask

  task automatic test_util_err();
    do_reset();
    req = 2'b01;
    step(1);
    util = 2'b01;
    step(1);
    util = 2'b11;
    for (int i = 0; i < 2; i++) begin
      step(1);
      total++; if (util_err !== 1'b1 || grant !== 2'b01) begin bad++; $display("FAIL uerr_on%0d got=%b/%b exp=1/01", i, util_err, grant); end
    end
    util = 2'b01;
    step(1);
    total++; if (util_err !== 1'b0 || grant !== 2'b01) begin bad++; $display("FAIL uerr_off got=%b/%b exp=0/01", util_err, grant); end
    util = 2'b00;
    req = 2'b00;
    step(2);
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 2'b01;
    step(1);
    util = 2'b01;
    step(1);
    total++; if (grant !== 2'b01 || bus_busy !== 1'b1) begin bad++; $display("FAIL ar_busy got=%b/%b exp=01/1", grant, bus_busy); end
    #3;
    reset = 1'b0;
    #1;
    total++; if (grant !== 2'b00 || bus_busy !== 1'b0) begin bad++; $display("FAIL ar_drop got=%b/%b exp=00/0", grant, bus_busy); end
    util = 2'b00;
    step(1);
    reset = 1'b1;
    step(1);
    total++; if (grant !== 2'b01 || grant_id !== 1'b0) begin bad++; $display("FAIL ar_regrant got=%b/%b exp=01/0", grant, grant_id); end
    req = 2'b00;
    step(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_order();
    test_timeout();
    test_util_err();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
